// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if -- bundle of the requester, MAR/MDR and SRAM signals
// of mem_access_ctrl. The controller uses the slave modport; whatever drives
// requests and models the SRAM uses the master modport.
interface mem_access_ctrl_if;
    // CPU requester
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_done;
    // Debug-loader requester
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_done;
    // Shared read-back and status
    logic [15:0] rdata;
    logic        busy;
    logic        grant;
    // MAR/MDR load path
    logic        LD_MAR;
    logic        LD_MDR;
    logic [15:0] MAR_In;
    logic [15:0] MDR_In;
    // SRAM side
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_done, dbg_done, rdata, busy, grant,
        output LD_MAR, LD_MDR, MAR_In, MDR_In,
        output mem_ce_n, mem_oe_n, mem_we_n
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_done, dbg_done, rdata, busy, grant,
        input  LD_MAR, LD_MDR, MAR_In, MDR_In,
        input  mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- arbitrates a CPU and a debug loader onto one
// asynchronous SRAM. Each transaction walks IDLE -> ADDR -> ACCESS
// (WAIT_CYCLES cycles) -> COMPLETE, loading MAR/MDR and driving the
// active-low SRAM strobes.
// Optional feature: define MEM_ACCESS_CTRL_RR_EN for round-robin arbitration
// of simultaneous requests; otherwise the CPU has fixed priority.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2   // legal 1..15
) (
    input  logic               Clk,
    input  logic               Reset,        // asynchronous, active low
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDR     = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic        grant_q;     // 0 = CPU, 1 = debug
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        any_req;
    logic        sel_dbg;     // arbitration result, meaningful in IDLE
    logic        start;       // IDLE -> ADDR edge: sample the winner

    assign any_req = bus.cpu_req | bus.dbg_req;
    assign start   = (state_q == IDLE) && any_req;

`ifdef MEM_ACCESS_CTRL_RR_EN
    logic rr_last_q;          // requester granted most recently

    // Round-robin: on a tie, grant whoever was not granted last.
    always_comb begin
        sel_dbg = bus.dbg_req & ~bus.cpu_req;
        if (bus.cpu_req && bus.dbg_req) begin
            sel_dbg = ~rr_last_q;
        end
    end

    // Round-robin pointer follows every grant; starts pointing at debug.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_last_q <= 1'b1;
        end else if (start) begin
            rr_last_q <= sel_dbg;
        end
    end
`else
    // Fixed priority: the CPU wins any tie.
    assign sel_dbg = bus.dbg_req & ~bus.cpu_req;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (any_req) state_d = ADDR;
            ADDR:     state_d = ACCESS;
            ACCESS:   if (cnt_q == 4'd0) state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and read-data register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= 4'd0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            if (start) begin
                grant_q <= sel_dbg;
                we_q    <= sel_dbg ? bus.dbg_we    : bus.cpu_we;
                addr_q  <= sel_dbg ? bus.dbg_addr  : bus.cpu_addr;
                wdata_q <= sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            end
            if (state_q == ADDR) begin
                cnt_q <= CNT_INIT;
            end else if (state_q == ACCESS) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (!we_q) begin
                    rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // Moore outputs decoded from the current state and captured request.
    always_comb begin
        bus.LD_MAR   = 1'b0;
        bus.LD_MDR   = 1'b0;
        bus.MAR_In   = 16'h0000;
        bus.MDR_In   = 16'h0000;
        bus.mem_ce_n = 1'b1;
        bus.mem_oe_n = 1'b1;
        bus.mem_we_n = 1'b1;
        bus.cpu_done = 1'b0;
        bus.dbg_done = 1'b0;
        unique case (state_q)
            ADDR: begin
                bus.LD_MAR = 1'b1;
                bus.MAR_In = addr_q;
                if (we_q) begin
                    bus.LD_MDR = 1'b1;
                    bus.MDR_In = wdata_q;
                end
            end
            ACCESS: begin
                // Exactly one of oe_n/we_n is driven low, chosen by we_q.
                bus.mem_ce_n = 1'b0;
                bus.mem_oe_n = we_q;
                bus.mem_we_n = ~we_q;
            end
            COMPLETE: begin
                bus.cpu_done = ~grant_q;
                bus.dbg_done = grant_q;
                if (!we_q) begin
                    bus.LD_MDR = 1'b1;
                    bus.MDR_In = rdata_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
